// File: rtl/multi_debouncer.sv
`timescale 1ns/1ps
// N-channel debouncer: 2-flop synchroniser, consecutive-sample filter, press/release pulses, optional auto-repeat.
// Release/repeat outputs are named release_pulse/repeat_pulse because "release" and "repeat" are SV keywords.
module multi_debouncer #(
  parameter int N_CH          = 4,
  parameter int STABLE_CYCLES = 8,
  parameter int ACTIVE_LOW    = 0,
  parameter int REPEAT_EN     = 0,
  parameter int REPEAT_DELAY  = 500,
  parameter int REPEAT_PERIOD = 100
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [N_CH-1:0] raw_in,
  output logic [N_CH-1:0] level,
  output logic [N_CH-1:0] press,
  output logic [N_CH-1:0] release_pulse,
  output logic [N_CH-1:0] repeat_pulse,
  output logic            any_press
);

  localparam int CW   = $clog2(STABLE_CYCLES + 1);
  localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RW   = $clog2(RMAX + 1);

  localparam logic [CW-1:0]   CNT_LAST = CW'(STABLE_CYCLES - 1);
  localparam logic [RW-1:0]   D_LAST   = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0]   P_LAST   = RW'(REPEAT_PERIOD - 1);
  localparam logic [N_CH-1:0] SYNC_RST = {N_CH{ACTIVE_LOW != 0}};

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] DELAY  = 2'd1;
  localparam logic [1:0] PERIOD = 2'd2;

  logic [N_CH-1:0] s1, s2, samp, accept;
  logic [CW-1:0]   cnt   [N_CH];
  logic [1:0]      state [N_CH];
  logic [RW-1:0]   rcnt  [N_CH];

  // Active-low sync flops reset to 1 so every channel starts released.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1 <= SYNC_RST;
      s2 <= SYNC_RST;
    end else begin
      s1 <= raw_in;
      s2 <= s1;
    end
  end

  assign samp = (ACTIVE_LOW != 0) ? ~s2 : s2;

  always_comb begin
    accept = '0;
    for (int i = 0; i < N_CH; i++)
      accept[i] = (samp[i] != level[i]) && (cnt[i] == CNT_LAST);
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < N_CH; i++) begin
      if (reset) begin
        cnt[i]           <= '0;
        level[i]         <= 1'b0;
        press[i]         <= 1'b0;
        release_pulse[i] <= 1'b0;
      end else begin
        press[i]         <= accept[i] & samp[i];
        release_pulse[i] <= accept[i] & ~samp[i];
        // A sample matching the current level is a bounce and restarts the count.
        if ((samp[i] == level[i]) || accept[i])
          cnt[i] <= '0;
        else
          cnt[i] <= cnt[i] + 1'b1;
        if (accept[i])
          level[i] <= samp[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < N_CH; i++) begin
      if (reset || (REPEAT_EN == 0)) begin
        state[i]        <= IDLE;
        rcnt[i]         <= '0;
        repeat_pulse[i] <= 1'b0;
      end else begin
        repeat_pulse[i] <= 1'b0;
        // Release wins over an expiring count in the same cycle.
        if (accept[i] && !samp[i]) begin
          state[i] <= IDLE;
          rcnt[i]  <= '0;
        end else begin
          case (state[i])
            IDLE: begin
              if (accept[i]) begin
                state[i] <= DELAY;
                rcnt[i]  <= '0;
              end
            end
            DELAY: begin
              if (rcnt[i] == D_LAST) begin
                repeat_pulse[i] <= 1'b1;
                state[i]        <= PERIOD;
                rcnt[i]         <= '0;
              end else begin
                rcnt[i] <= rcnt[i] + 1'b1;
              end
            end
            PERIOD: begin
              if (rcnt[i] == P_LAST) begin
                repeat_pulse[i] <= 1'b1;
                rcnt[i]         <= '0;
              end else begin
                rcnt[i] <= rcnt[i] + 1'b1;
              end
            end
            default: begin
              state[i] <= IDLE;
              rcnt[i]  <= '0;
            end
          endcase
        end
      end
    end
  end

  assign any_press = |(press | repeat_pulse);

endmodule
